apu_pulse_multi: RTL

APU_PULSE_MULTI -- requirements
Module: apu_pulse_multi

---
 rtl/apu_pkg.sv | 27 ++
 rtl/apu_pulse_multi_if.sv | 30 +++
 rtl/apu_pulse_ch.sv | 82 ++++++++
 rtl/apu_pulse_multi.sv | 84 ++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared definitions for the multi-channel pulse generator
package apu_pkg;

  // Periods below this are ultrasonic and are muted.
  localparam int MIN_PERIOD = 8;

  // Width of the config struct fields; channel PERIOD_W/LEN_W must not exceed it.
  localparam int CFG_FIELD_W = 16;

  typedef logic [1:0] duty_t;

  // Row = duty select, bit index = sequencer slot 0..7.
  localparam logic [3:0][7:0] DUTY_TABLE = {8'hF9, 8'h1E, 8'h06, 8'h02};

  // One channel's programmable settings, zero-extended to the common field width.
  typedef struct packed {
    logic [CFG_FIELD_W-1:0] period;
    duty_t                  duty;
    logic [CFG_FIELD_W-1:0] length;
    logic                   halt;
  } ch_cfg_t;

  function automatic logic duty_bit(input duty_t duty, input logic [2:0] seq);
    return DUTY_TABLE[duty][seq];
  endfunction

endpackage

// File: rtl/apu_pulse_multi_if.sv
// rtl/apu_pulse_multi_if.sv - config and output handshake bundle
interface apu_pulse_multi_if #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 11,
  parameter int LEN_W    = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic [1:0]          cfg_duty;
  logic [LEN_W-1:0]    cfg_length;
  logic                cfg_halt;
  logic                cfg_r_vld;
  logic                cfg_r_rdy;
  logic [NUM_CH-1:0]   output_s;
  logic                output_s_vld;
  logic                output_s_rdy;

  modport master (
    output cfg_ch, cfg_period, cfg_duty, cfg_length, cfg_halt, cfg_r_vld, output_s_rdy,
    input  cfg_r_rdy, output_s, output_s_vld
  );

  modport slave (
    input  cfg_ch, cfg_period, cfg_duty, cfg_length, cfg_halt, cfg_r_vld, output_s_rdy,
    output cfg_r_rdy, output_s, output_s_vld
  );

endinterface

// File: rtl/apu_pulse_ch.sv
// rtl/apu_pulse_ch.sv - one pulse channel: timer, sequencer, length counter, audible bit
module apu_pulse_ch
  import apu_pkg::*;
#(
  parameter int PERIOD_W = 11,
  parameter int LEN_W    = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    step_i,
  input  logic    frame_tick_i,
  input  logic    cfg_we_i,
  input  ch_cfg_t cfg_i,
  output logic    audible_d_o
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [2:0]          seq_q, seq_d;
  duty_t               duty_q, duty_d;
  logic                halt_q, halt_d;

  logic [PERIOD_W-1:0] cfg_period;
  logic [LEN_W-1:0]    cfg_length;

  // Fields wider than the channel saturate rather than wrap.
  assign cfg_period = (|(cfg_i.period >> PERIOD_W)) ? '1 : cfg_i.period[PERIOD_W-1:0];
  assign cfg_length = (|(cfg_i.length >> LEN_W)) ? '1 : cfg_i.length[LEN_W-1:0];

  // Next state: a config write replaces the whole channel and drops that edge's step.
  always_comb begin
    period_d = period_q;
    timer_d  = timer_q;
    length_d = length_q;
    seq_d    = seq_q;
    duty_d   = duty_q;
    halt_d   = halt_q;
    if (cfg_we_i) begin
      period_d = cfg_period;
      timer_d  = cfg_period;
      length_d = cfg_length;
      seq_d    = 3'd0;
      duty_d   = cfg_i.duty;
      halt_d   = cfg_i.halt;
    end else if (step_i) begin
      if (timer_q == '0) begin
        timer_d = period_q;
        seq_d   = seq_q + 3'd1;
      end else begin
        timer_d = timer_q - PERIOD_W'(1);
      end
      if (frame_tick_i && (length_q != '0) && !halt_q) begin
        length_d = length_q - LEN_W'(1);
      end
    end
  end

  // Audible bit of the post-edge state, registered by the top on each step.
  assign audible_d_o = duty_bit(duty_d, seq_d) && (length_d != '0) &&
                       (period_d >= PERIOD_W'(MIN_PERIOD));

  // Channel state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      timer_q  <= '0;
      length_q <= '0;
      seq_q    <= '0;
      duty_q   <= '0;
      halt_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      timer_q  <= timer_d;
      length_q <= length_d;
      seq_q    <= seq_d;
      duty_q   <= duty_d;
      halt_q   <= halt_d;
    end
  end

endmodule

// File: rtl/apu_pulse_multi.sv
// rtl/apu_pulse_multi.sv - multi-channel pulse generator with frame sequencer and output handshake
module apu_pulse_multi
  import apu_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int PERIOD_W  = 11,
  parameter int LEN_W     = 8,
  parameter int FRAME_DIV = 64
) (
  input logic               clk,
  input logic               reset,
  apu_pulse_multi_if.slave  apu
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_W = $clog2(FRAME_DIV);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               vld_q, vld_d;

  logic               step;
  logic               cfg_fire;
  logic               frame_tick;
  logic [NUM_CH-1:0]  cfg_we;
  logic [NUM_CH-1:0]  aud_d;
  ch_cfg_t            cfg_word;

  assign step       = vld_q && apu.output_s_rdy;
  assign cfg_fire   = apu.cfg_r_vld && !reset;
  assign frame_tick = step && (frame_q == FRAME_W'(FRAME_DIV - 1));

  assign cfg_word = '{period: CFG_FIELD_W'(apu.cfg_period),
                      duty:   apu.cfg_duty,
                      length: CFG_FIELD_W'(apu.cfg_length),
                      halt:   apu.cfg_halt};

  // Out-of-range channel numbers match no lane, so they are accepted and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg_fire && (apu.cfg_ch == CH_W'(i));

    apu_pulse_ch #(
      .PERIOD_W (PERIOD_W),
      .LEN_W    (LEN_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .step_i       (step),
      .frame_tick_i (frame_tick),
      .cfg_we_i     (cfg_we[i]),
      .cfg_i        (cfg_word),
      .audible_d_o  (aud_d[i])
    );
  end

  // Frame counter and output register advance only on a step.
  always_comb begin
    frame_d = frame_q;
    out_d   = out_q;
    vld_d   = 1'b1;
    if (step) begin
      frame_d = frame_q + FRAME_W'(1);
      out_d   = aud_d;
    end
  end

  // Top-level registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign apu.cfg_r_rdy    = !reset;
  assign apu.output_s     = out_q;
  assign apu.output_s_vld = vld_q;

endmodule
